// File: rtl/gsram_class_reader_pkg.sv
// Shared GSRAM geometry and widths for the accelerator.
// Also holds the class-reader state encoding.
package gsram_class_reader_pkg;

    localparam int GSRAM_ROWS = 10;
    localparam int GSRAM_COLS = 10;
    localparam int DATA_W     = 16;
    localparam int ACC_W      = 20;
    localparam int ADDR_W     = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_EMIT,
        S_DONE
    } rd_state_e;

endpackage

// File: rtl/gsram_class_reader_argmax.sv
// Running argmax over streamed class scores.
// Strictly greater replaces; ties keep the lower index.
module argmax_tracker #(
    parameter int ACC_W = 20,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             update,
    input  logic [ACC_W-1:0] value,
    input  logic [IDX_W-1:0] idx,
    output logic [ACC_W-1:0] best_val,
    output logic [IDX_W-1:0] best_idx
);

    logic take;

    // Column 0 seeds the best unconditionally.
    always_comb begin
        take = update &&
               ((idx == '0) || ($signed(value) > $signed(best_val)));
    end

    // Best value/index register.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            best_val <= '0;
            best_idx <= '0;
        end else if (take) begin
            best_val <= value;
            best_idx <= idx;
        end
    end

endmodule

// File: rtl/gsram_class_reader.sv
// Reads the 10x10 GSRAM, sums each column into a class
// score, streams the scores and reports the argmax class.
module gsram_class_reader #(
    parameter int DATA_W = gsram_class_reader_pkg::DATA_W,
    parameter int ROWS   = gsram_class_reader_pkg::GSRAM_ROWS,
    parameter int COLS   = gsram_class_reader_pkg::GSRAM_COLS,
    parameter int ACC_W  = gsram_class_reader_pkg::ACC_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              gsram_rd_en,
    output logic [3:0]        gsram_addr_row,
    output logic [3:0]        gsram_addr_col,
    input  logic [DATA_W-1:0] gsram_rdata,
    output logic              score_valid,
    input  logic              score_ready,
    output logic [ACC_W-1:0]  score_data,
    output logic [3:0]        score_idx,
    output logic [3:0]        class_out,
    output logic              busy,
    output logic              done
);

    import gsram_class_reader_pkg::*;

    rd_state_e        state;
    rd_state_e        state_nx;
    logic [3:0]       row;
    logic [3:0]       col;
    logic             rd_q;
    logic [ACC_W-1:0] acc;
    logic [3:0]       class_q;
    logic [ACC_W-1:0] best_val;
    logic [3:0]       best_idx;
    logic             go;
    logic             hs;
    logic             last_row;
    logic             last_col;
    logic [ACC_W-1:0] rdata_ext;

    // Decoded events shared by the processes below.
    always_comb begin
        go        = (state == S_IDLE) && start;
        hs        = (state == S_EMIT) && score_ready;
        last_row  = (row == 4'(ROWS - 1));
        last_col  = (col == 4'(COLS - 1));
        rdata_ext = {{(ACC_W - DATA_W){gsram_rdata[DATA_W-1]}},
                     gsram_rdata};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (start) state_nx = S_FETCH;
            S_FETCH: if (last_row) state_nx = S_DRAIN;
            S_DRAIN: state_nx = S_EMIT;
            S_EMIT:  if (score_ready)
                         state_nx = last_col ? S_DONE : S_FETCH;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Row/column address counters.
    always_ff @(posedge clk) begin
        if (reset || go) begin
            row <= '0;
            col <= '0;
        end else if (state == S_FETCH) begin
            row <= last_row ? 4'd0 : row + 4'd1;
        end else if (hs && !last_col) begin
            col <= col + 4'd1;
        end else if (state == S_DONE) begin
            col <= '0;
        end
    end

    // Delayed strobe qualifies the returning read word.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q <= 1'b0;
            acc  <= '0;
        end else begin
            rd_q <= gsram_rd_en;
            if (go || hs)  acc <= '0;
            else if (rd_q) acc <= acc + rdata_ext;
        end
    end

    // Holds the reported class between readouts.
    always_ff @(posedge clk) begin
        if (reset || go)          class_q <= '0;
        else if (state == S_DONE) class_q <= best_idx;
    end

    argmax_tracker #(
        .ACC_W (ACC_W),
        .IDX_W (4)
    ) u_argmax (
        .clk      (clk),
        .reset    (reset),
        .clear    (go),
        .update   (hs),
        .value    (acc),
        .idx      (col),
        .best_val (best_val),
        .best_idx (best_idx)
    );

    // Output decode; addresses idle at 0 when not reading.
    always_comb begin
        gsram_rd_en    = 1'b0;
        gsram_addr_row = '0;
        gsram_addr_col = '0;
        score_valid    = 1'b0;
        score_data     = '0;
        score_idx      = '0;
        busy           = (state != S_IDLE);
        done           = 1'b0;
        class_out      = class_q;
        unique case (state)
            S_FETCH: begin
                gsram_rd_en    = 1'b1;
                gsram_addr_row = row;
                gsram_addr_col = col;
            end
            S_EMIT: begin
                score_valid = 1'b1;
                score_data  = acc;
                score_idx   = col;
            end
            S_DONE: begin
                done      = 1'b1;
                class_out = best_idx;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_gsram_class_reader.sv
// Self-checking bench for gsram_class_reader with a
// column-sum/argmax reference model and random data.
module tb_gsram_class_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        gsram_rd_en;
    logic [3:0]  gsram_addr_row;
    logic [3:0]  gsram_addr_col;
    logic [15:0] gsram_rdata;
    logic        score_valid;
    logic        score_ready;
    logic [19:0] score_data;
    logic [3:0]  score_idx;
    logic [3:0]  class_out;
    logic        busy;
    logic        done;

    gsram_class_reader dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .gsram_rd_en    (gsram_rd_en),
        .gsram_addr_row (gsram_addr_row),
        .gsram_addr_col (gsram_addr_col),
        .gsram_rdata    (gsram_rdata),
        .score_valid    (score_valid),
        .score_ready    (score_ready),
        .score_data     (score_data),
        .score_idx      (score_idx),
        .class_out      (class_out),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    logic signed [15:0] mem [0:9][0:9];

    // Registered GSRAM model; garbage when not read.
    always @(posedge clk) begin
        if (gsram_rd_en)
            gsram_rdata <= mem[gsram_addr_row][gsram_addr_col];
        else
            gsram_rdata <= 16'($urandom);
    end

    int total = 0;
    int bad   = 0;
    int exp_score [10];
    int exp_class;
    int obs_score [10];
    int obs_idx   [10];
    int n_obs, done_cyc, done_cnt, obs_class;
    int stall_err, rd_stall, total_stall, timeout;
    bit aborted;

    function automatic void build_model();
        for (int c = 0; c < 10; c++) begin
            exp_score[c] = 0;
            for (int r = 0; r < 10; r++)
                exp_score[c] += int'(mem[r][c]);
        end
        exp_class = 0;
        for (int c = 1; c < 10; c++)
            if (exp_score[c] > exp_score[exp_class]) exp_class = c;
    endfunction

    function automatic void fill_zero();
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < 10; c++) mem[r][c] = 16'sd0;
    endfunction

    // Fill one column with small random values summing to s.
    function automatic void fill_col_sum(input int c, input int s);
        int acc;
        acc = 0;
        for (int r = 0; r < 9; r++) begin
            mem[r][c] = 16'($signed($urandom_range(0, 200)) - 100);
            acc += int'(mem[r][c]);
        end
        mem[9][c] = 16'(s - acc);
    endfunction

    task automatic apply_reset();
        reset = 1'b1;
        start = 1'b0;
        score_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    function automatic int pick_stall(input int mode);
        return (mode < 0) ? int'($urandom_range(0, 3)) : mode;
    endfunction

    task automatic run_readout(input int stall_mode,
                               input int restart_col,
                               input int reset_col);
        logic [19:0] held_d;
        logic [3:0]  held_i;
        bit holding, restarted;
        int stall_cnt, stall_tgt, cyc;
        n_obs = 0; done_cyc = -1; done_cnt = 0; obs_class = -1;
        stall_err = 0; rd_stall = 0; total_stall = 0;
        timeout = 0; aborted = 0;
        holding = 0; restarted = 0; stall_cnt = 0;
        stall_tgt = pick_stall(stall_mode);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
        while (cyc < 3000) begin
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc  = cyc;
                    obs_class = int'(class_out);
                end
            end
            if (done_cyc >= 0 && cyc > done_cyc) break;
            if (restart_col >= 0 && !restarted && gsram_rd_en &&
                int'(gsram_addr_col) == restart_col) begin
                start = 1'b1;
                restarted = 1;
            end else begin
                start = 1'b0;
            end
            if (reset_col >= 0 && gsram_rd_en &&
                int'(gsram_addr_col) == reset_col) begin
                reset = 1'b1;
                @(posedge clk);
                #1;
                reset = 1'b0;
                aborted = 1;
                break;
            end
            if (score_valid) begin
                if (gsram_rd_en) rd_stall++;
                if (holding && (score_data !== held_d ||
                                score_idx !== held_i))
                    stall_err++;
                if (stall_cnt < stall_tgt) begin
                    score_ready = 1'b0;
                    stall_cnt++;
                    total_stall++;
                    holding = 1;
                    held_d = score_data;
                    held_i = score_idx;
                end else begin
                    score_ready = 1'b1;
                    holding = 0;
                    if (n_obs < 10) begin
                        obs_score[n_obs] = int'($signed(score_data));
                        obs_idx[n_obs]   = int'(score_idx);
                    end
                    n_obs++;
                    stall_cnt = 0;
                    stall_tgt = pick_stall(stall_mode);
                end
            end else begin
                score_ready = 1'b1;
                holding = 0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        if (cyc >= 3000) timeout = 1;
        start = 1'b0;
        score_ready = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if (gsram_rd_en !== 1'b0 || gsram_addr_row !== 4'd0 ||
            gsram_addr_col !== 4'd0) begin
            bad++;
            $display("FAIL reset_rd: rd_en=%b row=%0d col=%0d want 0",
                     gsram_rd_en, gsram_addr_row, gsram_addr_col);
        end
        total++;
        if (score_valid !== 1'b0 || score_data !== 20'd0 ||
            score_idx !== 4'd0) begin
            bad++;
            $display("FAIL reset_score: v=%b d=%0d i=%0d want 0",
                     score_valid, score_data, score_idx);
        end
        total++;
        if (class_out !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctl: class=%0d busy=%b done=%b want 0",
                     class_out, busy, done);
        end
    endtask

    task automatic check_run(input string name, input int exp_done);
        total++;
        if (timeout !== 0) begin
            bad++;
            $display("FAIL %s_timeout: no done within budget", name);
        end
        total++;
        if (n_obs !== 10) begin
            bad++;
            $display("FAIL %s_count: got %0d scores want 10", name, n_obs);
        end
        for (int c = 0; c < 10; c++) begin
            total++;
            if (obs_score[c] !== exp_score[c] || obs_idx[c] !== c) begin
                bad++;
                $display("FAIL %s_score%0d: got %0d@%0d want %0d@%0d",
                         name, c, obs_score[c], obs_idx[c],
                         exp_score[c], c);
            end
        end
        total++;
        if (obs_class !== exp_class) begin
            bad++;
            $display("FAIL %s_class: got %0d want %0d",
                     name, obs_class, exp_class);
        end
        total++;
        if (done_cyc !== exp_done || done_cnt !== 1) begin
            bad++;
            $display("FAIL %s_done: at %0d x%0d want %0d x1",
                     name, done_cyc, done_cnt, exp_done);
        end
    endtask

    task automatic test_ramp();
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < 10; c++) mem[r][c] = 16'(r + 10 * c);
        build_model();
        apply_reset();
        run_readout(0, -1, -1);
        check_run("ramp", 121);
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (int'(class_out) !== exp_class || busy !== 1'b0) begin
            bad++;
            $display("FAIL ramp_hold: class=%0d busy=%b want %0d 0",
                     class_out, busy, exp_class);
        end
    endtask

    task automatic test_signed();
        fill_zero();
        for (int r = 0; r < 10; r++) begin
            mem[r][3] = -16'sd32768;
            mem[r][5] = 16'sd100;
        end
        build_model();
        run_readout(0, -1, -1);
        check_run("signed", 121);
    endtask

    task automatic test_tie();
        for (int c = 0; c < 10; c++)
            fill_col_sum(c, (c == 2 || c == 7) ? 500 : 0);
        build_model();
        run_readout(0, -1, -1);
        check_run("tie", 121);
    endtask

    task automatic test_backpressure();
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < 10; c++) mem[r][c] = 16'(r + 10 * c);
        build_model();
        run_readout(5, -1, -1);
        check_run("bp", 171);
        total++;
        if (stall_err !== 0 || rd_stall !== 0) begin
            bad++;
            $display("FAIL bp_stall: unstable=%0d reads=%0d want 0 0",
                     stall_err, rd_stall);
        end
    endtask

    task automatic test_start_busy();
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < 10; c++) mem[r][c] = 16'($urandom);
        build_model();
        run_readout(0, 4, -1);
        check_run("busy_start", 121);
    endtask

    task automatic test_reset_mid();
        int extra_done;
        run_readout(0, -1, 6);
        total++;
        if (aborted !== 1'b1 || done_cnt !== 0 || n_obs !== 6) begin
            bad++;
            $display("FAIL rst_mid_abort: ab=%b done=%0d n=%0d want 1 0 6",
                     aborted, done_cnt, n_obs);
        end
        total++;
        if (gsram_rd_en !== 1'b0 || gsram_addr_row !== 4'd0 ||
            gsram_addr_col !== 4'd0 || score_valid !== 1'b0 ||
            score_data !== 20'd0 || score_idx !== 4'd0 ||
            class_out !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_outs: rd=%b v=%b d=%0d cl=%0d b=%b",
                     gsram_rd_en, score_valid, score_data,
                     class_out, busy);
        end
        extra_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) extra_done++;
        end
        total++;
        if (extra_done !== 0) begin
            bad++;
            $display("FAIL rst_mid_quiet: %0d busy/done cycles want 0",
                     extra_done);
        end
        run_readout(0, -1, -1);
        check_run("rst_fresh", 121);
    endtask

    task automatic test_random();
        for (int k = 0; k < 3; k++) begin
            for (int r = 0; r < 10; r++)
                for (int c = 0; c < 10; c++)
                    mem[r][c] = 16'($urandom);
            build_model();
            run_readout(-1, -1, -1);
            check_run("random", 121 + total_stall);
            total++;
            if (stall_err !== 0 || rd_stall !== 0) begin
                bad++;
                $display("FAIL random_stall: unstable=%0d reads=%0d",
                         stall_err, rd_stall);
            end
        end
    endtask

    initial begin
        fill_zero();
        test_reset();
        test_ramp();
        test_signed();
        test_tie();
        test_backpressure();
        test_start_busy();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
